hit_event_writer: RTL and testbench

Producer side of the hit-FIFO link into `trigger`. Collects one event of 32-bit hit words from the front-end, buffers it, then writes it into the hit FIFO (`trigger`'s read FIFO) as an uninterrupted burst. Holds the FIFO idle for a guaranteed gap after each event, so the consumer's read timeout delimits events. Honours the FIFO's programmable-full backpressure.

---
 rtl/hit_event_writer.sv | 112 +++++++++++
 tb/tb_hit_event_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hit_event_writer.sv
// hit_event_writer: buffers one hit event, bursts it into the hit FIFO, then idles GAP_CYCLES.
// Define HIT_WRITER_COUNT_HDR_EN to prefix each burst with a length header word.
module hit_event_writer #(
    parameter int MAX_EVENT  = 256,
    parameter int GAP_CYCLES = 12,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      hit_dat,
    input  logic             hit_valid,
    input  logic             hit_last,
    output logic             hit_ready,
    output logic [31:0]      wrfifo_dat,
    output logic             wrfifo_wren,
    input  logic             wrfifo_prog_full,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);
    localparam int AW = $clog2(MAX_EVENT);
    localparam int PW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
`ifdef HIT_WRITER_COUNT_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef enum logic [1:0] {FILL, DRAIN, GAP} state_t;
    state_t state_q, state_d;

    logic [31:0]      mem [MAX_EVENT];
    logic [31:0]      rd_dat_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, n_words;
    logic [AW-1:0]    rd_addr;
    logic [GW-1:0]    gap_q, gap_d;
    logic             rd_vld_q, rd_vld_d, rd_hdr_q, rd_hdr_d, trunc_q, trunc_d;
    logic             hit_ready_q, hit_ready_d, wren_q, wren_d;
    logic [31:0]      dat_q, dat_d;
    logic [CNT_W-1:0] evt_q, evt_d, tc_q, tc_d;
    logic             accept, store, issue, wr, last_wr;

    assign accept  = hit_valid & hit_ready_q;
    assign store   = accept & (wr_ptr_q < PW'(MAX_EVENT));
    // wr_ptr doubles as the event length while draining; the header occupies read slot 0
    assign n_words = wr_ptr_q + PW'(HDR);
    assign rd_addr = AW'(rd_ptr_q - PW'(HDR));
    assign issue   = (state_q == DRAIN) & !wrfifo_prog_full & (rd_ptr_q < n_words);
    assign wr      = (state_q == DRAIN) & rd_vld_q & !wrfifo_prog_full;
    assign last_wr = wr & (rd_ptr_q == n_words);

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q[AW-1:0]] <= hit_dat;
        if (issue) rd_dat_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_hdr_q    <= 1'b0;
            trunc_q     <= 1'b0;
            gap_q       <= '0;
            hit_ready_q <= 1'b0;
            wren_q      <= 1'b0;
            dat_q       <= '0;
            evt_q       <= '0;
            tc_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_vld_q    <= rd_vld_d;
            rd_hdr_q    <= rd_hdr_d;
            trunc_q     <= trunc_d;
            gap_q       <= gap_d;
            hit_ready_q <= hit_ready_d;
            wren_q      <= wren_d;
            dat_q       <= dat_d;
            evt_q       <= evt_d;
            tc_q        <= tc_d;
        end
    end

    always_comb begin
        state_d = (state_q == FILL && accept && hit_last) ? DRAIN :
                  last_wr ? GAP :
                  (state_q == GAP && gap_q == GW'(GAP_CYCLES)) ? FILL : state_q;
    end

    always_comb begin
        wr_ptr_d    = last_wr ? '0 : wr_ptr_q + PW'(store);
        rd_ptr_d    = last_wr ? '0 : rd_ptr_q + PW'(issue);
        rd_vld_d    = issue | (rd_vld_q & !wr);
        rd_hdr_d    = issue ? (HDR != 0 && rd_ptr_q == '0) : (rd_hdr_q & !wr);
        trunc_d     = last_wr ? 1'b0 : (trunc_q | (accept & !store));
        gap_d       = (state_q == GAP) ? gap_q + GW'(1) : '0;
        hit_ready_d = (state_d == FILL);
        wren_d      = wr;
        dat_d       = wr ? (rd_hdr_q ? 32'(wr_ptr_q) : rd_dat_q) : dat_q;
        evt_d       = evt_q + CNT_W'(last_wr);
        tc_d        = (last_wr && trunc_q && tc_q != '1) ? tc_q + CNT_W'(1) : tc_q;
    end

    assign hit_ready   = hit_ready_q;
    assign wrfifo_wren = wren_q;
    assign wrfifo_dat  = dat_q;
    assign evt_cnt     = evt_q;
    assign trunc_cnt   = tc_q;
endmodule

// File: tb/tb_hit_event_writer.sv
// tb_hit_event_writer: scoreboard bench for hit_event_writer (MAX_EVENT=8, GAP_CYCLES=12).
module tb_hit_event_writer;
    localparam int ME = 8;
    localparam int GC = 12;
`ifdef HIT_WRITER_COUNT_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] hit_dat = '0;
    logic        hit_valid = 1'b0, hit_last = 1'b0, prog_full = 1'b0;
    logic        hit_ready, wren;
    logic [31:0] wdat;
    logic [15:0] evt_cnt, trunc_cnt;

    always #5 clk = ~clk;

    hit_event_writer #(.MAX_EVENT(ME), .GAP_CYCLES(GC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hit_dat(hit_dat), .hit_valid(hit_valid), .hit_last(hit_last),
        .hit_ready(hit_ready), .wrfifo_dat(wdat), .wrfifo_wren(wren),
        .wrfifo_prog_full(prog_full), .evt_cnt(evt_cnt), .trunc_cnt(trunc_cnt)
    );

    typedef struct packed {logic [31:0] d; logic first;} exp_t;
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] ev[$];
    int          checks = 0, failures = 0, idle_run = 0;
    bit          seen_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every FIFO write must match the head of the expected queue
    always @(negedge clk) begin
        if (wren) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got 0x%0h expected no write", wdat);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", wdat, e.d);
                if (e.first && seen_wr) chk("event_gap", 32'(idle_run >= GC), 32'd1);
            end
            seen_wr  = 1'b1;
            idle_run = 0;
        end else idle_run++;
        if (rst) seen_wr = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!hit_ready && k < 200) begin tick(); k++; end
        chk("ready_timeout", 32'(hit_ready), 32'd1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin tick(); k++; end
        tick();
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_writes(input int n);
        int seen = 0, k = 0;
        while (seen < n && k < 100) begin tick(); if (wren) seen++; k++; end
        chk("write_timeout", 32'(seen), 32'(n));
    endtask

    task automatic send(input bit push, input bit keep, output int stalls);
        int n = ev.size();
        stalls = 0;
        if (push) begin
            if (HDR != 0) exp_q.push_back({32'(n < ME ? n : ME), 1'b1});
            for (int i = 0; i < n && i < ME; i++) exp_q.push_back({ev[i], (HDR == 0 && i == 0)});
        end
        for (int i = 0; i < n; i++) begin
            int k = 0;
            hit_valid = 1'b1;
            hit_dat   = ev[i];
            hit_last  = (i == n - 1);
            while (!hit_ready && k < 200) begin tick(); k++; end
            stalls += k;
            tick();
        end
        hit_last  = 1'b0;
        hit_valid = keep;
    endtask

    initial begin
        int st;
        repeat (3) tick();
        chk("rst_hit_ready", 32'(hit_ready), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_wdat", wdat, 32'd0);
        chk("rst_evt_cnt", 32'(evt_cnt), 32'd0);
        chk("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_rise", 32'(hit_ready), 32'd1);

        // single 3-word event: latency, burst, gap length
        ev = '{32'h11, 32'h22, 32'h33};
        send(1'b1, 1'b0, st);
        chk("single_no_stall", 32'(st), 32'd0);
        tick();
        chk("lat_t1_idle", 32'(wren), 32'd0);
        for (int i = 0; i < 3 + HDR; i++) begin
            tick();
            chk("burst_wren", 32'(wren), 32'd1);
        end
        chk("single_evt_cnt", 32'(evt_cnt), 32'd1);
        for (int g = 0; g < GC; g++) begin
            tick();
            chk("gap_idle", {30'd0, wren, hit_ready}, 32'd0);
        end
        tick();
        chk("gap_end_ready", 32'(hit_ready), 32'd1);

        // 8-word event (exactly MAX_EVENT) with 3-cycle stall after the 2nd write
        ev = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        send(1'b1, 1'b0, st);
        wait_writes(2);
        prog_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wren", 32'(wren), 32'd0);
        end
        prog_full = 1'b0;
        wait_drain();
        chk("bp_evt_cnt", 32'(evt_cnt), 32'd2);
        chk("bp_trunc_cnt", 32'(trunc_cnt), 32'd0);

        // overflow: 10 words into an 8-deep buffer
        wait_ready();
        ev = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hB8, 32'hB9};
        send(1'b1, 1'b0, st);
        chk("ovf_ready_held", 32'(st), 32'd0);
        wait_drain();
        chk("ovf_trunc_cnt", 32'(trunc_cnt), 32'd1);
        chk("ovf_evt_cnt", 32'(evt_cnt), 32'd3);

        // back-to-back events with hit_valid held high
        wait_ready();
        ev = '{32'hC1, 32'hC2};
        send(1'b1, 1'b1, st);
        ev = '{32'hD1, 32'hD2, 32'hD3};
        send(1'b1, 1'b0, st);
        wait_drain();
        chk("b2b_evt_cnt", 32'(evt_cnt), 32'd5);
        chk("b2b_trunc_cnt", 32'(trunc_cnt), 32'd1);

        // reset after two writes of a 5-word event
        wait_ready();
        ev = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
        send(1'b0, 1'b0, st);
        if (HDR != 0) begin
            exp_q.push_back({32'd5, 1'b1});
            exp_q.push_back({32'hE0, 1'b0});
        end else begin
            exp_q.push_back({32'hE0, 1'b1});
            exp_q.push_back({32'hE1, 1'b0});
        end
        wait_writes(2);
        rst = 1'b1;
        tick();
        chk("abort_wren", 32'(wren), 32'd0);
        chk("abort_ready", 32'(hit_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_ready_rise", 32'(hit_ready), 32'd1);
        chk("abort_evt_cnt", 32'(evt_cnt), 32'd0);
        repeat (4) tick();
        ev = '{32'h77};
        send(1'b1, 1'b0, st);
        wait_drain();
        chk("post_rst_evt_cnt", 32'(evt_cnt), 32'd1);

        repeat (20) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
